wb_trace_fifo: RTL and testbench

Buffers architectural write-back events produced by the `mips` core for an in-order checker or trace dumper downstream. It captures register-file writes (GRF) and data-memory writes (DM), up to two per cycle. It queues them in program order as tagged records and drains them over a valid/ready handshake. Overflow is flagged and counted, never stalls the core.

---
 rtl/wb_trace_pkg.sv | 24 ++
 rtl/wb_trace_mem.sv | 42 ++++
 rtl/wb_trace_fifo.sv | 154 +++++++++++++++
 tb/tb_wb_trace_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_pkg
// Description : Shared types and constants for the write-back trace FIFO.
//               Defines the record kind encodings and the 97-bit packed
//               trace record {kind, pc, addr, data}.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_trace_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } wb_rec_t;

    localparam int REC_W = $bits(wb_rec_t);

endpackage : wb_trace_pkg
`default_nettype wire

// File: rtl/wb_trace_mem.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_mem
// Description : DEPTH x REC_W record storage with two synchronous write
//               ports and one asynchronous read port. Holds no reset; the
//               owner qualifies the read data with its own occupancy state.
// Ports       : clk       - rising-edge clock
//               i_we0/1   - write enables for port 0 / port 1
//               i_waddr0/1- write slot indices (distinct when both enabled)
//               i_wdata0/1- records to store
//               i_raddr   - read slot index
//               o_rdata   - record at i_raddr (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_mem
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we0,
    input  logic [AW-1:0] i_waddr0,
    input  wb_rec_t       i_wdata0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_waddr1,
    input  wb_rec_t       i_wdata1,
    input  logic [AW-1:0] i_raddr,
    output wb_rec_t       o_rdata
);

    wb_rec_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we0) r_mem[i_waddr0] <= i_wdata0;
        if (i_we1) r_mem[i_waddr1] <= i_wdata1;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : wb_trace_mem
`default_nettype wire

// File: rtl/wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_trace_fifo
// Description : Queues GRF and DM write-back events (up to two per cycle) in
//               program order as tagged records and drains them over a
//               valid/ready handshake. Never stalls the producer: events that
//               do not fit are dropped, flagged (sticky overflow) and counted
//               in a saturating drop counter.
// Config      : WB_TRACE_ZERO_FILTER_EN - when defined, GRF writes to $0 are
//               silently discarded (not queued, not counted as drops).
// Ports       : clk, reset (async, active-low)
//               grf_we/pc/addr/data - register-file write event
//               dm_we/pc/addr/data  - data-memory write event
//               out_valid/ready     - drain handshake
//               out_kind/pc/addr/data - head record (zero while empty)
//               overflow, drop_cnt  - drop status
// Revision    : 1.0 - initial release
// ============================================================================
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grf_we,
    input  logic [31:0]      grf_pc,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_data,
    input  logic             dm_we,
    input  logic [31:0]      dm_pc,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_kind,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_grf_ev;
    logic             w_dm_ev;
    logic [AW:0]      w_free;
    logic             w_free_ge1;
    logic             w_free_ge2;
    logic             w_push_grf;
    logic             w_push_dm;
    logic             w_pop;
    logic [1:0]       w_n_push;
    logic [1:0]       w_n_drop;
    logic [CNT_W:0]   w_drop_sum;
    logic [CNT_W-1:0] w_drop_next;
    wb_rec_t          w_grf_rec;
    wb_rec_t          w_dm_rec;
    wb_rec_t          w_wdata0;
    logic             w_we0;
    logic             w_we1;
    wb_rec_t          w_head;

`ifdef WB_TRACE_ZERO_FILTER_EN
    assign w_grf_ev = grf_we && (grf_addr != 5'd0);
`else
    assign w_grf_ev = grf_we;
`endif
    assign w_dm_ev = dm_we;

    // Free space is taken from the registered count, so a same-cycle pop
    // never makes room for a same-cycle push.
    assign w_free     = C_DEPTH - r_count;
    assign w_free_ge1 = (w_free >= (AW+1)'(1));
    assign w_free_ge2 = (w_free >= (AW+1)'(2));

    // GRF always claims the first free slot; DM needs a second slot when
    // both events arrive together.
    assign w_push_grf = w_grf_ev && w_free_ge1;
    assign w_push_dm  = w_dm_ev && (w_grf_ev ? w_free_ge2 : w_free_ge1);

    assign w_n_push = {1'b0, w_push_grf} + {1'b0, w_push_dm};
    assign w_n_drop = {1'b0, (w_grf_ev && !w_push_grf)}
                    + {1'b0, (w_dm_ev && !w_push_dm)};

    assign w_pop = out_valid && out_ready;

    assign w_drop_sum  = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_n_drop);
    assign w_drop_next = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

    assign w_grf_rec = '{kind: KIND_GRF, pc: grf_pc,
                         addr: {27'd0, grf_addr}, data: grf_data};
    assign w_dm_rec  = '{kind: KIND_DM, pc: dm_pc, addr: dm_addr, data: dm_data};

    // Port 0 writes the first pushed event at wr_ptr (GRF if present,
    // otherwise DM); port 1 is only used for DM behind a GRF.
    assign w_we0    = w_push_grf || w_push_dm;
    assign w_we1    = w_push_grf && w_push_dm;
    assign w_wdata0 = w_push_grf ? w_grf_rec : w_dm_rec;

    wb_trace_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (clk),
        .i_we0    (w_we0),
        .i_waddr0 (r_wr_ptr),
        .i_wdata0 (w_wdata0),
        .i_we1    (w_we1),
        .i_waddr1 (r_wr_ptr + AW'(1)),
        .i_wdata1 (w_dm_rec),
        .i_raddr  (r_rd_ptr),
        .o_rdata  (w_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count  <= r_count + (AW+1)'(w_n_push) - (AW+1)'(w_pop);
            if (w_n_drop != 2'd0) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_next;
            end
        end
    end

    // Storage is not reset, so the head is masked while empty; this also
    // gives all-zero outputs the instant reset is asserted.
    assign out_valid = (r_count != '0);
    assign out_kind  = out_valid ? w_head.kind : 1'b0;
    assign out_pc    = out_valid ? w_head.pc   : 32'd0;
    assign out_addr  = out_valid ? w_head.addr : 32'd0;
    assign out_data  = out_valid ? w_head.data : 32'd0;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule : wb_trace_fifo
`default_nettype wire

// File: tb/tb_wb_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_trace_fifo
// Description : Directed testbench for wb_trace_fifo with a queue-based
//               scoreboard of expected records plus drop/overflow model.
// Config      : WB_TRACE_ZERO_FILTER_EN - must match the DUT build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_trace_fifo;
    import wb_trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             grf_we, dm_we, out_ready;
    logic [31:0]      grf_pc, grf_data, dm_pc, dm_addr, dm_data;
    logic [4:0]       grf_addr;
    logic             out_valid, out_kind, overflow;
    logic [31:0]      out_pc, out_addr, out_data;
    logic [CNT_W-1:0] drop_cnt;

    wb_rec_t sb[$];
    int      vectors = 0;
    int      fails   = 0;
    int      m_drop  = 0;
    logic    m_ovf   = 1'b0;

    always #5 clk = ~clk;

    wb_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_data(grf_data),
        .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are applied just after an edge, the head is
    // checked against the scoreboard if a pop will happen, the model is
    // advanced, and status is checked just after the next edge.
    task automatic cyc(input logic gw, input logic [31:0] gp, input logic [4:0] ga,
                       input logic [31:0] gd, input logic dw, input logic [31:0] dp,
                       input logic [31:0] da, input logic [31:0] dd, input logic rdy);
        int      free;
        int      nd;
        logic    g_ev;
        logic    pop;
        wb_rec_t tmp[$];
        grf_we = gw; grf_pc = gp; grf_addr = ga; grf_data = gd;
        dm_we = dw; dm_pc = dp; dm_addr = da; dm_data = dd;
        out_ready = rdy;
        free = DEPTH - sb.size();
        pop  = (sb.size() != 0) && rdy;
        if (pop) chk("head", {out_kind, out_pc, out_addr, out_data}, sb[0]);
`ifdef WB_TRACE_ZERO_FILTER_EN
        g_ev = gw && (ga != 5'd0);
`else
        g_ev = gw;
`endif
        nd = 0;
        if (g_ev) begin
            if (free >= 1) begin
                tmp.push_back('{kind: KIND_GRF, pc: gp, addr: {27'd0, ga}, data: gd});
                free--;
            end else nd++;
        end
        if (dw) begin
            if (free >= 1) begin
                tmp.push_back('{kind: KIND_DM, pc: dp, addr: da, data: dd});
                free--;
            end else nd++;
        end
        if (pop) void'(sb.pop_front());
        foreach (tmp[i]) sb.push_back(tmp[i]);
        if (nd != 0) begin
            m_ovf  = 1'b1;
            m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
        end
        @(posedge clk); #1;
        chk("out_valid", out_valid, (sb.size() != 0));
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_rec"}, {out_kind, out_pc, out_addr, out_data}, 97'd0);
        chk({tag, "_ovf"}, overflow, 1'b0);
        chk({tag, "_drop"}, drop_cnt, 16'd0);
    endtask

    initial begin
        reset = 1'b0;
        grf_we = 0; grf_pc = 0; grf_addr = 0; grf_data = 0;
        dm_we = 0; dm_pc = 0; dm_addr = 0; dm_data = 0; out_ready = 0;
        #1;
        check_cleared("reset");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        idle(1'b1);

        // Single GRF write, drained immediately, then empty.
        cyc(1'b1, 32'h3000, 5'd8, 32'h1234, 1'b0, 0, 0, 0, 1'b1);
        chk("single_kind", out_kind, KIND_GRF);
        chk("single_addr", out_addr, 32'd8);
        chk("single_data", out_data, 32'h1234);
        idle(1'b1);
        idle(1'b1);

        // Dual push held, then drained GRF then DM.
        cyc(1'b1, 32'h3004, 5'd9, 32'hA, 1'b1, 32'h3008, 32'h10, 32'hB, 1'b0);
        idle(1'b0);
        chk("dual_first_kind", out_kind, KIND_GRF);
        idle(1'b1);
        chk("dual_second_kind", out_kind, KIND_DM);
        chk("dual_second_addr", out_addr, 32'h10);
        idle(1'b1);

        // 17 single pushes into 16 slots: the last one is dropped.
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0)
                cyc(1'b1, 32'h4000 + 32'(i*4), 5'(i+1), 32'hC000 + 32'(i), 1'b0, 0, 0, 0, 1'b0);
            else
                cyc(1'b0, 0, 0, 0, 1'b1, 32'h4000 + 32'(i*4), 32'h100 + 32'(i*4),
                    32'hD000 + 32'(i), 1'b0);
        end
        chk("full_count", sb.size(), 16);
        chk("full_drop", drop_cnt, 16'd1);

        // Full: push plus pop -> pop completes, push dropped.
        cyc(1'b1, 32'h5000, 5'd3, 32'h5555, 1'b0, 0, 0, 0, 1'b1);
        chk("fullpp_drop", drop_cnt, 16'd2);

        // 15 queued, dual push -> GRF stored, DM dropped.
        cyc(1'b1, 32'h5004, 5'd4, 32'h6666, 1'b1, 32'h5008, 32'h200, 32'h7777, 1'b0);
        chk("15_dual_drop", drop_cnt, 16'd3);
        for (int i = 0; i < 17; i++) idle(1'b1);

        // Queue 5 records then pulse reset between edges.
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'h6000 + 32'(i*4), 5'(i+10), 32'(i), 1'b0, 0, 0, 0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_cleared("midreset");
        sb.delete(); m_drop = 0; m_ovf = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        idle(1'b0);

        // $0 write.
        cyc(1'b1, 32'h7000, 5'd0, 32'hDEAD, 1'b0, 0, 0, 0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Pseudo-random mix of events and back-pressure.
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), $urandom,
                1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < 20; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule : tb_wb_trace_fifo
`default_nettype wire
